// File: rtl/idi_mem_sink.sv
// idi_mem_sink: memory-backed IDI target model.
// Read/write requests arrive on a valid/ready channel. Writes are stored in a
// DEPTH-word array. Each request gets one in-order response after RD_LAT cycles.
// Credits (the outstanding count) bound the response FIFO, so no response is dropped.
// Optional feature macro: IDI_SINK_ADDR_CHECK_EN. When it is defined, an
// out-of-range address is flagged with rsp_err. Otherwise the word index wraps.
module idi_mem_sink #(
  parameter int                 DATA_W    = 32,
  parameter int                 ADDR_W    = 64,
  parameter int                 DEPTH     = 256,
  parameter int                 RD_LAT    = 2,
  parameter int                 RSP_DEPTH = 4,
  parameter logic [DATA_W-1:0]  DEF_RDATA = 32'h12345678
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              is_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rdata,
  output logic              rsp_err
);

  localparam int BO = $clog2(DATA_W / 8);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(RSP_DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(RSP_DEPTH - 1);

  // Wrap-around increment for the response buffer pointers.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PTR_LAST) begin
      return '0;
    end else begin
      return p + 1'b1;
    end
  endfunction

  // Handshakes and address decode.
  logic              accept_s;
  logic              pop_s;
  logic [IW-1:0]     idx_s;
  logic              addr_ok_s;
  logic              addr_unused;

  assign accept_s    = req_valid && req_ready;
  assign pop_s       = rsp_valid && rsp_ready;
  assign idx_s       = addr[BO+IW-1:BO];
  assign addr_unused = ^addr;

`ifdef IDI_SINK_ADDR_CHECK_EN
  assign addr_ok_s = (addr[ADDR_W-1:BO+IW] == '0);
`else
  assign addr_ok_s = 1'b1;
`endif

  // Backing store and the per-word written flags.
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0]  written_r;
  logic [DATA_W-1:0] samp_data_s;

  // Array words are not reset: only the written flags decide what a read sees.
  always_ff @(posedge clk) begin
    if (accept_s && is_write && addr_ok_s) begin
      mem_r[idx_s] <= wdata;
    end
  end

  // Written flags: cleared by reset, set on an accepted in-range write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      written_r <= '0;
    end else if (accept_s && is_write && addr_ok_s) begin
      written_r[idx_s] <= 1'b1;
    end
  end

  // Response payload sampled at the accept edge (acks and bad addresses carry 0).
  always_comb begin
    samp_data_s = '0;
    if (!addr_ok_s) begin
      samp_data_s = '0;
    end else if (is_write) begin
      samp_data_s = '0;
    end else if (written_r[idx_s]) begin
      samp_data_s = mem_r[idx_s];
    end else begin
      samp_data_s = DEF_RDATA;
    end
  end

  // Latency pipe: RD_LAT stages of {valid, write, err, data}.
  logic [RD_LAT-1:0] pv_r;
  logic [RD_LAT-1:0] pw_r;
  logic [RD_LAT-1:0] pe_r;
  logic [DATA_W-1:0] pd_r [RD_LAT];

  // Shift the latency pipe. Reset drops everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_r <= '0;
      pw_r <= '0;
      pe_r <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pd_r[i] <= '0;
      end
    end else begin
      pv_r[0] <= accept_s;
      pw_r[0] <= is_write;
      pe_r[0] <= !addr_ok_s;
      pd_r[0] <= samp_data_s;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_r[i] <= pv_r[i-1];
        pw_r[i] <= pw_r[i-1];
        pe_r[i] <= pe_r[i-1];
        pd_r[i] <= pd_r[i-1];
      end
    end
  end

  // Response FIFO: the output registers act as the head, and a small buffer sits behind it.
  logic              in_v_s;
  logic              head_free_s;
  logic              buf_nempty_s;
  logic              load_buf_s;
  logic              load_in_s;
  logic              push_s;
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [CW-1:0]     bcnt_r;
  logic              rbuf_w_r [RSP_DEPTH];
  logic              rbuf_e_r [RSP_DEPTH];
  logic [DATA_W-1:0] rbuf_d_r [RSP_DEPTH];

  assign in_v_s       = pv_r[RD_LAT-1];
  assign head_free_s  = !rsp_valid || pop_s;
  assign buf_nempty_s = (bcnt_r != '0);
  assign load_buf_s   = head_free_s && buf_nempty_s;
  assign load_in_s    = head_free_s && !buf_nempty_s && in_v_s;
  assign push_s       = in_v_s && !load_in_s;

  // Buffer payload storage. Occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (push_s) begin
      rbuf_w_r[wr_ptr_r] <= pw_r[RD_LAT-1];
      rbuf_e_r[wr_ptr_r] <= pe_r[RD_LAT-1];
      rbuf_d_r[wr_ptr_r] <= pd_r[RD_LAT-1];
    end
  end

  // Buffer pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      bcnt_r   <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (load_buf_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_s, load_buf_s})
        2'b10:   bcnt_r <= bcnt_r + 1'b1;
        2'b01:   bcnt_r <= bcnt_r - 1'b1;
        default: bcnt_r <= bcnt_r;
      endcase
    end
  end

  // Head register: refill from the buffer first, then from the pipe. Hold payload when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_err   <= 1'b0;
      rdata     <= '0;
    end else if (load_buf_s) begin
      rsp_valid <= 1'b1;
      rsp_write <= rbuf_w_r[rd_ptr_r];
      rsp_err   <= rbuf_e_r[rd_ptr_r];
      rdata     <= rbuf_d_r[rd_ptr_r];
    end else if (load_in_s) begin
      rsp_valid <= 1'b1;
      rsp_write <= pw_r[RD_LAT-1];
      rsp_err   <= pe_r[RD_LAT-1];
      rdata     <= pd_r[RD_LAT-1];
    end else if (head_free_s) begin
      rsp_valid <= 1'b0;
    end
  end

  // Outstanding credits: this counts the pipe, the buffer and the head together.
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nx_s;

  // Next credit count. It is unchanged when an accept and a pop coincide.
  always_comb begin
    cnt_nx_s = cnt_r;
    case ({accept_s, pop_s})
      2'b10:   cnt_nx_s = cnt_r + 1'b1;
      2'b01:   cnt_nx_s = cnt_r - 1'b1;
      default: cnt_nx_s = cnt_r;
    endcase
  end

  // Credit register and registered req_ready. req_ready stays low while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= '0;
      req_ready <= 1'b0;
    end else begin
      cnt_r     <= cnt_nx_s;
      req_ready <= (cnt_nx_s < CNT_FULL);
    end
  end

endmodule

// File: tb/tb_idi_mem_sink.sv
// Directed self-checking bench for idi_mem_sink with the default parameters.
// The bench picks the expected values for the address-check feature from
// IDI_SINK_ADDR_CHECK_EN.
module tb_idi_mem_sink;

  localparam logic [31:0] DEF = 32'h12345678;
`ifdef IDI_SINK_ADDR_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        req_valid = 1'b0;
  logic        is_write  = 1'b0;
  logic        rsp_ready = 1'b0;
  logic [63:0] addr      = 64'd0;
  logic [31:0] wdata     = 32'd0;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_write;
  logic [31:0] rdata;
  logic        rsp_err;

  int          checks = 0;
  int          errors = 0;
  int          nxt;
  int          nrsp;
  bit          acc;
  logic [31:0] got [6];

  idi_mem_sink #(
    .DATA_W(32), .ADDR_W(64), .DEPTH(256), .RD_LAT(2), .RSP_DEPTH(4),
    .DEF_RDATA(32'h12345678)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .is_write(is_write),
    .addr(addr), .wdata(wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rdata(rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic w, input logic [63:0] a, input logic [31:0] d);
    chk({tag, "_ready"}, {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1;
    is_write  = w;
    addr      = a;
    wdata     = d;
    step();
    req_valid = 1'b0;
    is_write  = 1'b0;
  endtask

  // Called just after the accept edge with rsp_ready = 1. It checks latency and payload, then consumes.
  task automatic expect_rsp(input string tag, input logic w, input logic [31:0] d, input logic e);
    int lat = 0;
    while (!rsp_valid && lat < 10) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'd2);
    chk({tag, "_valid"}, {63'd0, rsp_valid}, 64'd1);
    chk({tag, "_write"}, {63'd0, rsp_write}, {63'd0, w});
    chk({tag, "_rdata"}, {32'd0, rdata}, {32'd0, d});
    chk({tag, "_err"}, {63'd0, rsp_err}, {63'd0, e});
    step();
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk("rst_ready", {63'd0, req_ready}, 64'd0);
    chk("rst_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_rdata", {32'd0, rdata}, 64'd0);
    chk("rst_write", {63'd0, rsp_write}, 64'd0);
    chk("rst_err", {63'd0, rsp_err}, 64'd0);
    rst_n = 1'b1;
    step();
    chk("rel_ready", {63'd0, req_ready}, 64'd1);

    // Test 1: an unwritten word returns DEF exactly RD_LAT cycles after accept
    rsp_ready = 1'b1;
    do_req("t1", 1'b0, 64'h40, 32'd0);
    chk("t1_lat0", {63'd0, rsp_valid}, 64'd0);
    step();
    chk("t1_lat1", {63'd0, rsp_valid}, 64'd0);
    step();
    chk("t1_valid", {63'd0, rsp_valid}, 64'd1);
    chk("t1_rdata", {32'd0, rdata}, {32'd0, DEF});
    chk("t1_write", {63'd0, rsp_write}, 64'd0);
    step();
    chk("t1_empty", {63'd0, rsp_valid}, 64'd0);
    chk("t1_hold", {32'd0, rdata}, {32'd0, DEF});

    // Test 2: a write followed by a read of the same word on the next cycle
    chk("t2_wr_ready", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; is_write = 1'b1; addr = 64'h40; wdata = 32'hDEADBEEF;
    step();
    chk("t2_rd_ready", {63'd0, req_ready}, 64'd1);
    is_write = 1'b0;
    step();
    req_valid = 1'b0;
    chk("t2_idle", {63'd0, rsp_valid}, 64'd0);
    step();
    chk("t2_ack_valid", {63'd0, rsp_valid}, 64'd1);
    chk("t2_ack_write", {63'd0, rsp_write}, 64'd1);
    chk("t2_ack_rdata", {32'd0, rdata}, 64'd0);
    step();
    chk("t2_rd_valid", {63'd0, rsp_valid}, 64'd1);
    chk("t2_rd_write", {63'd0, rsp_write}, 64'd0);
    chk("t2_rd_rdata", {32'd0, rdata}, 64'hDEADBEEF);
    step();
    chk("t2_empty", {63'd0, rsp_valid}, 64'd0);

    // Preload words 1..6 so that the order of the reads can be seen in the data
    for (int k = 1; k <= 6; k++) begin
      do_req("pre", 1'b1, 64'(k * 4), 32'hC0DE0000 + 32'(k));
      expect_rsp("pre_ack", 1'b1, 32'd0, 1'b0);
    end

    // Test 3: rsp_ready low, 6 back-to-back reads. Only 4 are accepted.
    rsp_ready = 1'b0;
    nxt = 0;
    for (int c = 0; c < 6; c++) begin
      req_valid = 1'b1; addr = 64'((nxt + 1) * 4);
      acc = req_ready;
      step();
      if (acc) nxt++;
    end
    chk("t3_accepted", 64'(nxt), 64'd4);
    chk("t3_full_ready", {63'd0, req_ready}, 64'd0);
    chk("t3_head_valid", {63'd0, rsp_valid}, 64'd1);
    chk("t3_head_stable", {32'd0, rdata}, 64'hC0DE0001);

    // Test 4: a pop while full. No accept that cycle; req_ready returns on the next one.
    rsp_ready = 1'b1;
    addr = 64'((nxt + 1) * 4);
    chk("t4_hs_cycle_ready", {63'd0, req_ready}, 64'd0);
    nrsp = 0;
    got[nrsp] = rdata; nrsp++;
    step();
    chk("t4_ready_reassert", {63'd0, req_ready}, 64'd1);
    for (int c = 0; c < 30; c++) begin
      if (nrsp == 6) break;
      req_valid = (nxt < 6);
      addr = 64'((nxt + 1) * 4);
      acc = req_ready && req_valid;
      if (rsp_valid) begin
        got[nrsp] = rdata; nrsp++;
      end
      step();
      if (acc) nxt++;
    end
    req_valid = 1'b0;
    chk("t3_total_rsp", 64'(nrsp), 64'd6);
    chk("t3_total_acc", 64'(nxt), 64'd6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t3_order%0d", i), {32'd0, got[i]}, {32'd0, 32'hC0DE0001 + 32'(i)});
    end
    step(); step(); step();
    chk("t3_no_extra", {63'd0, rsp_valid}, 64'd0);

    // Test 5: reset with 3 outstanding drops them all
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      do_req("t5_fill", 1'b0, 64'h40, 32'd0);
    end
    step(); step();
    chk("t5_pre_valid", {63'd0, rsp_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", {63'd0, rsp_valid}, 64'd0);
    chk("t5_rst_ready", {63'd0, req_ready}, 64'd0);
    chk("t5_rst_rdata", {32'd0, rdata}, 64'd0);
    step(); step();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    step();
    chk("t5_rel_ready", {63'd0, req_ready}, 64'd1);
    chk("t5_no_stale", {63'd0, rsp_valid}, 64'd0);
    do_req("t5_rd", 1'b0, 64'h40, 32'd0);
    expect_rsp("t5_rd", 1'b0, DEF, 1'b0);
    chk("t5_after", {63'd0, rsp_valid}, 64'd0);

    // Test 6: out-of-range write to index 256
    do_req("t6_wr", 1'b1, 64'h400, 32'hFEEDF00D);
    expect_rsp("t6_wr", 1'b1, 32'd0, CHK);
    do_req("t6_rd0", 1'b0, 64'h0, 32'd0);
    expect_rsp("t6_rd0", 1'b0, CHK ? DEF : 32'hFEEDF00D, 1'b0);
    do_req("t6_rdoor", 1'b0, 64'h400, 32'd0);
    expect_rsp("t6_rdoor", 1'b0, CHK ? 32'd0 : 32'hFEEDF00D, CHK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
